// File: rtl/divider_controller.sv
// rtl/divider_controller.sv - sequencing FSM for a shift/subtract divider datapath
// Optional zero-divisor abort is enabled by defining DIV_ZERO_CHECK_EN.
module divider_controller #(
  parameter int DATA_WIDTH = 6,
  parameter int STEP_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] divisor_in,
  input  logic                  result_ack,
  input  logic                  divident_gt_divisor,
  input  logic                  done,
  output logic                  initialize,
  output logic                  load_divident,
  output logic                  sh_en,
  output logic                  ready,
  output logic                  busy,
  output logic                  result_valid,
  output logic                  error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [STEP_WIDTH-1:0] STEP_LIMIT = STEP_WIDTH'(DATA_WIDTH + 2);

  logic [2:0]            state_q, state_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic [STEP_WIDTH-1:0] step_inc;
  logic                  zero_div;
  logic                  calc_step;

`ifdef DIV_ZERO_CHECK_EN
  assign zero_div = (divisor_in == '0);
`else
  logic unused_divisor;
  assign unused_divisor = ^divisor_in;
  assign zero_div       = 1'b0;
`endif

  assign step_inc = step_q + 1'b1;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = zero_div ? S_ERR : S_INIT;
      end
      S_INIT: begin
        state_d = S_CALC;
        step_d  = '0;
      end
      S_CALC: begin
        step_d = step_inc;
        // Watchdog: the datapath never reported completion within its step budget
        if (done)                         state_d = S_HOLD;
        else if (step_inc == STEP_LIMIT)  state_d = S_ERR;
      end
      S_HOLD: begin
        if (result_ack) state_d = start ? S_INIT : S_IDLE;
      end
      S_ERR: begin
        if (result_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  assign calc_step     = (state_q == S_CALC) && !done;
  assign initialize    = (state_q == S_INIT);
  assign load_divident = calc_step && divident_gt_divisor;
  assign sh_en         = calc_step && !divident_gt_divisor;
  assign ready         = (state_q == S_IDLE);
  assign busy          = (state_q == S_INIT) || (state_q == S_CALC);
  assign result_valid  = (state_q == S_HOLD);
  assign error         = (state_q == S_ERR);

endmodule
